// File: rtl/apb_reg_slave.sv
// APB4 slave exposing NUM_REGS memory-mapped registers at BASE_ADDR, with byte
// strobes, programmable wait states, per-register read-only mask and error response.
module apb_reg_slave #(
    parameter int unsigned                ADDR_W      = 32,
    parameter int unsigned                DATA_W      = 32,
    parameter int unsigned                NUM_REGS    = 8,
    parameter logic [ADDR_W-1:0]          BASE_ADDR   = ADDR_W'(32'h0000_A000),
    parameter int unsigned                WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0]        RO_MASK     = '0,
    parameter logic [DATA_W-1:0]          RESET_VAL   = '0
) (
    input  logic                          pclk,
    input  logic                          presetn,
    input  logic                          psel,
    input  logic                          penable,
    input  logic                          pwrite,
    input  logic [ADDR_W-1:0]             paddr,
    input  logic [DATA_W-1:0]             pwdata,
    input  logic [DATA_W/8-1:0]           pstrb,
    output logic [DATA_W-1:0]             prdata,
    output logic                          pready,
    output logic                          pslverr,
    output logic [NUM_REGS*DATA_W-1:0]    reg_out,
    output logic [NUM_REGS-1:0]           wr_pulse
);

    localparam int unsigned       BYTES      = DATA_W / 8;
    localparam int unsigned       LSB        = $clog2(BYTES);
    localparam int unsigned       IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W-1:0] SPAN       = ADDR_W'(NUM_REGS * BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BYTES - 1);
    localparam logic [3:0]        WS_INIT    = 4'(WAIT_STATES);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t             state;
    logic [3:0]         wait_cnt;
    logic               acc_write;
    logic               acc_hit;
    logic               acc_ro;
    logic [IDX_W-1:0]   acc_idx;
    logic [DATA_W-1:0]  regs [NUM_REGS];

    logic [ADDR_W-1:0]  off;
    logic               dec_hit;
    logic [IDX_W-1:0]   dec_idx;
    logic               complete;
    logic               xfer_err;

    // Index is forced to 0 on a miss so every array/mask lookup stays in range.
    always_comb begin
        off     = paddr - BASE_ADDR;
        dec_hit = (paddr >= BASE_ADDR) && (off < SPAN) && ((off & ALIGN_MASK) == '0);
        dec_idx = dec_hit ? IDX_W'(off >> LSB) : '0;
    end

    assign complete = (state == ACCESS) && psel && penable && (wait_cnt == '0);
    assign xfer_err = !acc_hit || (acc_write && acc_ro);

    assign pready  = complete;
    assign pslverr = complete && xfer_err;
    assign prdata  = (complete && !xfer_err && !acc_write) ? regs[acc_idx] : '0;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
        assign reg_out[i*DATA_W +: DATA_W] = regs[i];
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            acc_write <= 1'b0;
            acc_hit   <= 1'b0;
            acc_ro    <= 1'b0;
            acc_idx   <= '0;
            wr_pulse  <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else begin
            wr_pulse <= '0;
            case (state)
                IDLE: begin
                    if (psel && !penable) begin
                        state     <= ACCESS;
                        wait_cnt  <= WS_INIT;
                        acc_write <= pwrite;
                        acc_hit   <= dec_hit;
                        acc_ro    <= dec_hit && RO_MASK[dec_idx];
                        acc_idx   <= dec_idx;
                    end
                end
                ACCESS: begin
                    if (!psel) begin
                        state <= IDLE;
                    end else if (penable) begin
                        if (wait_cnt != '0) begin
                            wait_cnt <= wait_cnt - 4'd1;
                        end else begin
                            state <= IDLE;
                            // Write data and strobes are taken at the completing edge.
                            if (acc_write && !xfer_err) begin
                                for (int unsigned b = 0; b < BYTES; b++) begin
                                    if (pstrb[b]) begin
                                        regs[acc_idx][8*b +: 8] <= pwdata[8*b +: 8];
                                    end
                                end
                                wr_pulse[acc_idx] <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Runs a zero-wait and a 3-wait slave in lockstep on one APB bus and checks both
// against a register-array reference model every cycle.
module tb_apb_reg_slave;

    logic        pclk    = 1'b0;
    logic        presetn = 1'b0;
    logic        psel    = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite  = 1'b0;
    logic [31:0] paddr   = '0;
    logic [31:0] pwdata  = '0;
    logic [3:0]  pstrb   = '0;

    logic [1:0][31:0]  prdata_v;
    logic [1:0]        pready_v;
    logic [1:0]        pslverr_v;
    logic [1:0][255:0] reg_out_v;
    logic [1:0][7:0]   wr_pulse_v;

    always #5 pclk = ~pclk;

    apb_reg_slave #(.WAIT_STATES(0), .RO_MASK(8'h01)) u_fast (
        .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata_v[0]), .pready(pready_v[0]), .pslverr(pslverr_v[0]),
        .reg_out(reg_out_v[0]), .wr_pulse(wr_pulse_v[0])
    );

    apb_reg_slave #(.WAIT_STATES(3), .RO_MASK(8'h01)) u_slow (
        .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata_v[1]), .pready(pready_v[1]), .pslverr(pslverr_v[1]),
        .reg_out(reg_out_v[1]), .wr_pulse(wr_pulse_v[1])
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [31:0] model [2][8];
    logic [7:0]  pend  [2];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic bit in_map(input logic [31:0] a);
        return (a >= 32'hA000) && (a < 32'hA020) && (a % 4 == 0);
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a - 32'hA000) / 4);
    endfunction

    task automatic sample(input int d, input bit done, input bit err, input bit wr, input int idx);
        logic [255:0] exp_regs;
        logic [31:0]  exp_rd;
        for (int i = 0; i < 8; i++) exp_regs[i*32 +: 32] = model[d][i];
        exp_rd = (done && !err && !wr) ? model[d][idx] : 32'h0;
        chk($sformatf("pready[%0d]", d),   256'(pready_v[d]),   256'(done));
        chk($sformatf("pslverr[%0d]", d),  256'(pslverr_v[d]),  256'(done && err));
        chk($sformatf("prdata[%0d]", d),   256'(prdata_v[d]),   256'(exp_rd));
        chk($sformatf("wr_pulse[%0d]", d), 256'(wr_pulse_v[d]), 256'(pend[d]));
        chk($sformatf("reg_out[%0d]", d),  reg_out_v[d],        exp_regs);
        pend[d] = '0;
    endtask

    task automatic commit(input int d, input int idx);
        for (int b = 0; b < 4; b++)
            if (pstrb[b]) model[d][idx][8*b +: 8] = pwdata[8*b +: 8];
        pend[d] = 8'(1 << idx);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) model[d][i] = '0;
            pend[d] = '0;
        end
    endtask

    // One transfer; bus is live for access cycles k < ab, vary re-randomises write data while waiting.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input int ab, input bit vary);
        bit hit = in_map(addr);
        int idx = hit ? idx_of(addr) : 0;
        bit err = !hit || (wr && idx == 0);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
        @(negedge pclk);
        for (int d = 0; d < 2; d++) sample(d, 1'b0, err, wr, idx);
        @(posedge pclk); #1;
        penable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k >= ab) begin
                psel = 1'b0; penable = 1'b0;
            end else if (vary && k > 0) begin
                pwdata = $urandom; pstrb = 4'($urandom);
            end
            @(negedge pclk);
            for (int d = 0; d < 2; d++) sample(d, (k < ab) && (k == ws_of(d)), err, wr, idx);
            @(posedge pclk);
            for (int d = 0; d < 2; d++)
                if ((k < ab) && (k == ws_of(d)) && wr && !err) commit(d, idx);
            #1;
        end
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic idle_cycle();
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        for (int d = 0; d < 2; d++) sample(d, 1'b0, 1'b0, 1'b0, 0);
        @(posedge pclk); #1;
    endtask

    task automatic reset_mid_transfer();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hA008; pwdata = $urandom; pstrb = 4'hF;
        @(negedge pclk);
        for (int d = 0; d < 2; d++) sample(d, 1'b0, 1'b0, 1'b1, 2);
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        sample(0, 1'b1, 1'b0, 1'b1, 2);
        sample(1, 1'b0, 1'b0, 1'b1, 2);
        @(posedge pclk);
        commit(0, 2);
        #1;
        presetn = 1'b0;
        @(negedge pclk);
        for (int d = 0; d < 2; d++) sample(d, 1'b0, 1'b0, 1'b1, 2);
        @(posedge pclk);
        model_reset();
        #1;
        presetn = 1'b1; psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        for (int d = 0; d < 2; d++) sample(d, 1'b0, 1'b0, 1'b0, 0);
        @(posedge pclk); #1;
    endtask

    function automatic logic [31:0] pick_addr();
        int unsigned r = $urandom % 10;
        if (r < 7)       return 32'hA000 + 32'(4 * ($urandom % 8));
        else if (r == 7) return 32'hA000 + 32'(4 * ($urandom % 8)) + 32'(1 + $urandom % 3);
        else if (r == 8) return 32'hA020 + 32'($urandom % 32);
        else             return 32'h9FE0 + 32'($urandom % 32);
    endfunction

    initial begin
        model_reset();
        presetn = 1'b0;
        @(posedge pclk); #1;
        @(negedge pclk);
        for (int d = 0; d < 2; d++) sample(d, 1'b0, 1'b0, 1'b0, 0);
        @(posedge pclk); #1;
        presetn = 1'b1;

        for (int i = 0; i < 8; i++) xfer(1'b0, 32'hA000 + 32'(4 * i), '0, '0, 99, 1'b0);

        xfer(1'b1, 32'hA004, 32'hDEAD_BEEF, 4'b1111, 99, 1'b0);
        xfer(1'b0, 32'hA004, '0, '0, 99, 1'b0);
        xfer(1'b1, 32'hA004, 32'h1122_3344, 4'b0101, 99, 1'b0);
        xfer(1'b0, 32'hA004, '0, '0, 99, 1'b0);

        xfer(1'b0, 32'hA020, '0, '0, 99, 1'b0);
        xfer(1'b1, 32'hA002, 32'h5555_AAAA, 4'hF, 99, 1'b0);
        xfer(1'b1, 32'hA000, 32'hCAFE_F00D, 4'hF, 99, 1'b0);
        xfer(1'b1, 32'hA010, 32'h0BAD_CAFE, 4'h0, 99, 1'b0);

        xfer(1'b1, 32'hA00C, 32'h1234_5678, 4'hF, 1, 1'b0);
        xfer(1'b0, 32'hA00C, '0, '0, 99, 1'b0);
        reset_mid_transfer();

        xfer(1'b1, 32'hA01C, 32'hA5A5_0F0F, 4'hF, 99, 1'b1);
        xfer(1'b0, 32'hA01C, '0, '0, 99, 1'b0);
        xfer(1'b1, 32'hA018, 32'h7777_8888, 4'b1001, 99, 1'b1);
        xfer(1'b0, 32'hA018, '0, '0, 99, 1'b0);

        for (int n = 0; n < 200; n++) begin
            int ab = (($urandom % 8) == 0) ? int'($urandom % 4) : 99;
            xfer(1'($urandom), pick_addr(), $urandom, 4'($urandom), ab, 1'b1);
        end

        idle_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
